// File: rtl/int_cvt_pkg.sv
// Shared types for the int_to_int command queue: converter control fields and halfword write masks.
// wmask_of() maps a command's precision/position fields to the register-file halfword enables.
package int_cvt_pkg;

  typedef struct packed {
    logic src_prec;
    logic dst_prec;
    logic src_signed;
    logic dst_signed;
    logic src_pos;
    logic dst_pos;
  } cvt_ctrl_t;

  localparam int CTRL_W = $bits(cvt_ctrl_t);

  localparam logic [1:0] WMASK_LO  = 2'b01;
  localparam logic [1:0] WMASK_HI  = 2'b10;
  localparam logic [1:0] WMASK_ALL = 2'b11;

  // Only a 32b->16b narrowing writes a single half; everything else writes the whole word.
  function automatic logic [1:0] wmask_of(input cvt_ctrl_t c);
    if (c.src_prec && !c.dst_prec) begin
      return c.dst_pos ? WMASK_HI : WMASK_LO;
    end
    return WMASK_ALL;
  endfunction

endpackage

// File: rtl/int_cvt_fifo.sv
// Synchronous FIFO holding queued conversion commands; head entry is visible combinationally.
// Push/pop are pre-qualified by the parent; count changes by +1, -1 or 0 per cycle.
module int_cvt_fifo
  import int_cvt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/int_cvt_issue_queue.sv
// Queues conversion commands, issues the head to the external int_to_int converter and
// registers its result, tag and halfword mask for the register-file write port.
module int_cvt_issue_queue
  import int_cvt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  input  logic                   cmd_src_prec,
  input  logic                   cmd_dst_prec,
  input  logic                   cmd_src_signed,
  input  logic                   cmd_dst_signed,
  input  logic                   cmd_src_pos,
  input  logic                   cmd_dst_pos,
  input  logic [31:0]            cmd_data,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   cvt_instr_vld,
  output logic                   cvt_src_prec,
  output logic                   cvt_dst_prec,
  output logic                   cvt_src_signed,
  output logic                   cvt_dst_signed,
  output logic                   cvt_src_pos,
  output logic                   cvt_dst_pos,
  output logic [31:0]            cvt_in_reg,
  input  logic [31:0]            cvt_out_reg,
  input  logic                   cvt_result_vld,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [31:0]            rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [1:0]             rsp_wmask,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   proto_err
);

  localparam int ENTRY_W = CTRL_W + 32 + TAG_W;

  typedef struct packed {
    cvt_ctrl_t        ctrl;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t                 w_cmd_entry;
  entry_t                 w_head;
  logic [ENTRY_W-1:0]     w_head_raw;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_issue;

  logic                   r_rsp_vld;
  logic [31:0]            r_rsp_data;
  logic [TAG_W-1:0]       r_rsp_tag;
  logic [1:0]             r_rsp_wmask;
  logic                   r_proto_err;

  assign w_cmd_entry.ctrl = '{src_prec:   cmd_src_prec,
                              dst_prec:   cmd_dst_prec,
                              src_signed: cmd_src_signed,
                              dst_signed: cmd_dst_signed,
                              src_pos:    cmd_src_pos,
                              dst_pos:    cmd_dst_pos};
  assign w_cmd_entry.data = cmd_data;
  assign w_cmd_entry.tag  = cmd_tag;

  // Ready comes from occupancy alone: a full queue stays closed even if it pops this cycle.
  assign cmd_rdy = !w_full;
  assign w_push  = cmd_vld & cmd_rdy;
  assign w_issue = !w_empty & (!r_rsp_vld | rsp_rdy);

  int_cvt_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (w_cmd_entry),
    .i_pop   (w_issue),
    .o_rdata (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (fifo_cnt)
  );

  assign w_head = w_head_raw;

  assign cvt_instr_vld  = w_issue;
  assign cvt_src_prec   = w_head.ctrl.src_prec;
  assign cvt_dst_prec   = w_head.ctrl.dst_prec;
  assign cvt_src_signed = w_head.ctrl.src_signed;
  assign cvt_dst_signed = w_head.ctrl.dst_signed;
  assign cvt_src_pos    = w_head.ctrl.src_pos;
  assign cvt_dst_pos    = w_head.ctrl.dst_pos;
  assign cvt_in_reg     = w_head.data;

  // The converter is combinational, so its result is captured in the same cycle as the issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_rsp_wmask <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_rsp_vld   <= 1'b1;
        r_rsp_data  <= cvt_out_reg;
        r_rsp_tag   <= w_head.tag;
        r_rsp_wmask <= wmask_of(w_head.ctrl);
      end else if (rsp_rdy) begin
        r_rsp_vld   <= 1'b0;
      end
      if (cvt_result_vld != w_issue) r_proto_err <= 1'b1;
    end
  end

  assign rsp_vld   = r_rsp_vld;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_wmask = r_rsp_wmask;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_int_cvt_issue_queue.sv
// Bench for int_cvt_issue_queue: behavioural int_to_int converter on the cvt_* ports and a
// queue-based scoreboard of expected responses in command order.
module tb_int_cvt_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic              cmd_src_prec, cmd_dst_prec, cmd_src_signed, cmd_dst_signed;
  logic              cmd_src_pos, cmd_dst_pos;
  logic [31:0]       cmd_data;
  logic [TAG_W-1:0]  cmd_tag;
  logic              cvt_instr_vld;
  logic              cvt_src_prec, cvt_dst_prec, cvt_src_signed, cvt_dst_signed;
  logic              cvt_src_pos, cvt_dst_pos;
  logic [31:0]       cvt_in_reg;
  logic [31:0]       cvt_out_reg;
  logic              cvt_result_vld;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [31:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic [1:0]        rsp_wmask;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic              proto_err;
  logic              force_bad;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [1:0]       wmask;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic longint src_val(input logic [31:0] w, input logic is32, input logic sgn);
    if (is32) begin
      if (sgn) return longint'($signed(w));
      return longint'(w);
    end
    if (sgn) return longint'($signed(w[15:0]));
    return longint'(w[15:0]);
  endfunction

  function automatic longint sat(input longint v, input logic is32, input logic sgn);
    longint mx, mn;
    if (is32) begin
      if (sgn) begin mx = 64'sd2147483647; mn = -64'sd2147483648; end
      else     begin mx = 64'sd4294967295; mn = 64'sd0; end
    end else begin
      if (sgn) begin mx = 64'sd32767; mn = -64'sd32768; end
      else     begin mx = 64'sd65535; mn = 64'sd0; end
    end
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Saturating int_to_int converter; 16b->16b converts both halfword lanes.
  function automatic logic [31:0] conv(input logic sp, input logic dp, input logic ss,
                                       input logic ds, input logic spos, input logic dpos,
                                       input logic [31:0] d);
    longint hi, lo, v;
    logic [31:0] w;
    if (!sp && !dp) begin
      lo = sat(src_val({16'h0, d[15:0]}, 1'b0, ss), 1'b0, ds);
      hi = sat(src_val({16'h0, d[31:16]}, 1'b0, ss), 1'b0, ds);
      return {hi[15:0], lo[15:0]};
    end
    w = sp ? d : (spos ? {16'h0, d[31:16]} : {16'h0, d[15:0]});
    v = sat(src_val(w, sp, ss), dp, ds);
    if (dp) return v[31:0];
    return dpos ? {v[15:0], 16'h0} : {16'h0, v[15:0]};
  endfunction

  assign cvt_out_reg    = conv(cvt_src_prec, cvt_dst_prec, cvt_src_signed, cvt_dst_signed,
                               cvt_src_pos, cvt_dst_pos, cvt_in_reg);
  assign cvt_result_vld = force_bad ? 1'b0 : cvt_instr_vld;

  int_cvt_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_src_prec(cmd_src_prec), .cmd_dst_prec(cmd_dst_prec),
    .cmd_src_signed(cmd_src_signed), .cmd_dst_signed(cmd_dst_signed),
    .cmd_src_pos(cmd_src_pos), .cmd_dst_pos(cmd_dst_pos),
    .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .cvt_instr_vld(cvt_instr_vld),
    .cvt_src_prec(cvt_src_prec), .cvt_dst_prec(cvt_dst_prec),
    .cvt_src_signed(cvt_src_signed), .cvt_dst_signed(cvt_dst_signed),
    .cvt_src_pos(cvt_src_pos), .cvt_dst_pos(cvt_dst_pos),
    .cvt_in_reg(cvt_in_reg), .cvt_out_reg(cvt_out_reg), .cvt_result_vld(cvt_result_vld),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_wmask(rsp_wmask), .fifo_cnt(fifo_cnt), .proto_err(proto_err)
  );

  // Scoreboard: inputs change just after posedge, so negedge sees the handshakes of the next edge.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] wm;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_vld && rsp_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_unexpected: got data=%h tag=%0d, required no response", rsp_data, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_data, rsp_tag, rsp_wmask} !== {e.data, e.tag, e.wmask}) begin
            n_fail++;
            $display("FAIL scoreboard_rsp: got data=%h tag=%0d wmask=%b, required data=%h tag=%0d wmask=%b",
                     rsp_data, rsp_tag, rsp_wmask, e.data, e.tag, e.wmask);
          end
        end
      end
      if (cmd_vld && cmd_rdy) begin
        wm = (cmd_src_prec && !cmd_dst_prec) ? (cmd_dst_pos ? 2'b10 : 2'b01) : 2'b11;
        e.data  = conv(cmd_src_prec, cmd_dst_prec, cmd_src_signed, cmd_dst_signed,
                       cmd_src_pos, cmd_dst_pos, cmd_data);
        e.tag   = cmd_tag;
        e.wmask = wm;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ctl order: {src_prec, dst_prec, src_signed, dst_signed, src_pos, dst_pos}
  task automatic set_cmd(input logic [5:0] ctl, input logic [31:0] d, input logic [TAG_W-1:0] t);
    {cmd_src_prec, cmd_dst_prec, cmd_src_signed, cmd_dst_signed, cmd_src_pos, cmd_dst_pos} = ctl;
    cmd_data = d;
    cmd_tag  = t;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({rsp_vld, rsp_data, rsp_tag, rsp_wmask, proto_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b data=%h tag=%0d wmask=%b perr=%b, required all zero",
               rsp_vld, rsp_data, rsp_tag, rsp_wmask, proto_err);
    end
    n_checks++;
    if (fifo_cnt !== 0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d required 0", fifo_cnt);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (cmd_rdy !== 1'b1 || proto_err !== 1'b0 || rsp_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy=%b perr=%b vld=%b, required 1 0 0", cmd_rdy, proto_err, rsp_vld);
    end
  endtask

  task automatic test_directed;
    logic [5:0]  ctl  [4] = '{6'b101101, 6'b000100, 6'b011010, 6'b011100};
    logic [31:0] din  [4] = '{32'h0001_2345, 32'hFFFF_0001, 32'h8000_0005, 32'h0000_FFFE};
    logic [31:0] dexp [4] = '{32'h7FFF_0000, 32'h7FFF_0001, 32'h0000_0000, 32'hFFFF_FFFE};
    logic [1:0]  mexp [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(ctl[i], din[i], TAG_W'(i + 1));
      cmd_vld = 1'b1;
      tick();
      cmd_vld = 1'b0;
      n_checks++;
      if (rsp_vld !== 1'b0 || fifo_cnt !== 1) begin
        n_fail++;
        $display("FAIL directed%0d_accept: got vld=%b cnt=%0d, required 0 1", i, rsp_vld, fifo_cnt);
      end
      tick();
      n_checks++;
      if (rsp_vld !== 1'b1 || rsp_data !== dexp[i] || rsp_wmask !== mexp[i] || rsp_tag !== TAG_W'(i + 1)) begin
        n_fail++;
        $display("FAIL directed%0d_rsp: got vld=%b data=%h wmask=%b tag=%0d, required 1 %h %b %0d",
                 i, rsp_vld, rsp_data, rsp_wmask, rsp_tag, dexp[i], mexp[i], i + 1);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    rsp_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(6'b110000, $urandom, TAG_W'(i));
      cmd_vld = 1'b1;
      if (cmd_rdy) acc++;
      tick();
    end
    cmd_vld = 1'b0;
    n_checks++;
    if (acc != 5 || cmd_rdy !== 1'b0 || fifo_cnt !== 4 || rsp_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full: got acc=%0d rdy=%b cnt=%0d vld=%b, required 5 0 4 1", acc, cmd_rdy, fifo_cnt, rsp_vld);
    end
    rsp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rsp_vld !== 1'b1 || rsp_tag !== TAG_W'(k)) begin
        n_fail++;
        $display("FAIL b2b_drain%0d: got vld=%b tag=%0d, required 1 %0d", k, rsp_vld, rsp_tag, k);
      end
      tick();
    end
    n_checks++;
    if (rsp_vld !== 1'b0 || fifo_cnt !== 0) begin
      n_fail++;
      $display("FAIL b2b_empty: got vld=%b cnt=%0d, required 0 0", rsp_vld, fifo_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(6'b111100, $urandom, TAG_W'(10 + i));
      cmd_vld = 1'b1;
      tick();
    end
    cmd_vld = 1'b0;
    n_checks++;
    if (fifo_cnt !== 3 || rsp_vld !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got cnt=%0d vld=%b, required 3 1", fifo_cnt, rsp_vld);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (rsp_vld !== 1'b0 || fifo_cnt !== 0 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_post: got vld=%b cnt=%0d rdy=%b, required 0 0 1", rsp_vld, fifo_cnt, cmd_rdy);
    end
    rsp_rdy = 1'b1;
    repeat (8) begin
      if (rsp_vld) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rstmid_stale: got %0d responses, required 0", seen);
    end
  endtask

  task automatic test_proto_err;
    rsp_rdy = 1'b1;
    set_cmd(6'b110000, 32'hA5A5_0000, TAG_W'(7));
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
    n_checks++;
    if (cvt_instr_vld !== 1'b1 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL proto_pre: got issue=%b perr=%b, required 1 0", cvt_instr_vld, proto_err);
    end
    force_bad = 1'b1;
    tick();
    force_bad = 1'b0;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++; $display("FAIL proto_set: got %b required 1", proto_err);
    end
    repeat (5) tick();
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++; $display("FAIL proto_sticky: got %b required 1", proto_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL proto_clear: got %b required 0", proto_err);
    end
  endtask

  task automatic test_random;
    int exp_cnt;
    int waited;
    logic [31:0] d;
    for (int cyc = 0; cyc < 800; cyc++) begin
      exp_cnt = exp_q.size() - (rsp_vld ? 1 : 0);
      n_checks++;
      if (int'(fifo_cnt) != exp_cnt || cmd_rdy !== (exp_cnt < DEPTH)) begin
        n_fail++;
        $display("FAIL random_occupancy cyc%0d: got cnt=%0d rdy=%b, required cnt=%0d rdy=%b",
                 cyc, fifo_cnt, cmd_rdy, exp_cnt, exp_cnt < DEPTH);
      end
      case ($urandom_range(0, 5))
        0:       d = 32'h8000_0000;
        1:       d = 32'h7FFF_FFFF;
        2:       d = 32'h0000_8000;
        3:       d = 32'hFFFF_7FFF;
        default: d = $urandom;
      endcase
      set_cmd(6'($urandom), d, TAG_W'($urandom));
      cmd_vld = 1'($urandom_range(0, 1));
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_vld = 1'b0;
    rsp_rdy = 1'b1;
    waited = 0;
    while ((exp_q.size() != 0 || rsp_vld) && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0 || rsp_vld !== 1'b0 || fifo_cnt !== 0) begin
      n_fail++;
      $display("FAIL random_drain: got pending=%0d vld=%b cnt=%0d after %0d cycles, required 0 0 0",
               exp_q.size(), rsp_vld, fifo_cnt, waited);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; rsp_rdy = 1'b0; force_bad = 1'b0;
    set_cmd(6'b0, 32'h0, '0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_proto_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
